// File: rtl/aardvark_bus_pkg.sv
`default_nettype none
// ============================================================================
// aardvark_bus_pkg : shared types and constants for the accumulator data bus
// Rev 1.0
// ============================================================================
package aardvark_bus_pkg;

    localparam int BUS_W = 8;

    // One-hot so each grant output is a flop bit with no decode.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_G0   = 3'b010,
        ST_G1   = 3'b100
    } arb_state_e;

    localparam int ST_G0_BIT = 1;
    localparam int ST_G1_BIT = 2;

endpackage : aardvark_bus_pkg
`default_nettype wire

// File: rtl/bus_mux2_w.sv
`default_nettype none
// ============================================================================
// bus_mux2_w : parameterised WIDTH-bit 2:1 data mux
// Rev 1.0
// ============================================================================
module bus_mux2_w
    import aardvark_bus_pkg::*;
#(
    parameter int WIDTH = BUS_W
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_in0,
    input  logic [WIDTH-1:0] i_in1,
    output logic [WIDTH-1:0] o_out
);

    assign o_out = i_sel ? i_in1 : i_in0;

endmodule : bus_mux2_w
`default_nettype wire

// File: rtl/bus_arbiter2.sv
`default_nettype none
// ============================================================================
// bus_arbiter2 : two-requester round-robin arbiter with bounded hold time
// Rev 1.0
// ============================================================================
module bus_arbiter2
    import aardvark_bus_pkg::*;
#(
    parameter int WIDTH    = BUS_W,
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             bus_valid,
    output logic [WIDTH-1:0] bus_out
);

    localparam bit               PREEMPT_EN  = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(PREEMPT_EN ? MAX_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

    arb_state_e       state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic             owner_idx;
    logic             owner_req;
    logic             other_req;
    logic             grant_en;
    logic             grant_idx;
    logic [WIDTH-1:0] mux_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        grant_en   = 1'b0;
        grant_idx  = 1'b0;

        owner_idx  = state_q[ST_G1_BIT];
        owner_req  = owner_idx ? req1 : req0;
        other_req  = owner_idx ? req0 : req1;

        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    grant_en  = 1'b1;
                    grant_idx = ~last_q;
                end else if (req0 || req1) begin
                    grant_en  = 1'b1;
                    grant_idx = req1;
                end
            end

            ST_G0, ST_G1: begin
                if (!owner_req) begin
                    if (other_req) begin
                        grant_en  = 1'b1;
                        grant_idx = ~owner_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (other_req) begin
                    // Count only while the other side is actually waiting.
                    if (PREEMPT_EN && (hold_cnt_q == C_HOLD_LAST)) begin
                        grant_en  = 1'b1;
                        grant_idx = ~owner_idx;
                    end else if (hold_cnt_q != C_CNT_MAX) begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end else begin
                    hold_cnt_d = '0;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase

        if (grant_en) begin
            state_d    = grant_idx ? ST_G1 : ST_G0;
            sel_d      = grant_idx;
            last_d     = grant_idx;
            hold_cnt_d = '0;
        end
    end

    bus_mux2_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .i_sel (sel_q),
        .i_in0 (din0),
        .i_in1 (din1),
        .o_out (mux_out)
    );

    assign gnt0      = state_q[ST_G0_BIT];
    assign gnt1      = state_q[ST_G1_BIT];
    assign sel       = sel_q;
    assign bus_valid = gnt0 | gnt1;
    assign bus_out   = bus_valid ? mux_out : '0;

endmodule : bus_arbiter2
`default_nettype wire

// File: tb/tb_bus_arbiter2.sv
`default_nettype none
// ============================================================================
// tb_bus_arbiter2 : directed scenarios plus random traffic against a model
// Rev 1.0
// ============================================================================
module tb_bus_arbiter2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] din0 = 8'h00;
    logic [7:0] din1 = 8'h00;

    // Index 0: MAX_HOLD=4, index 1: MAX_HOLD=0.
    logic [1:0] gnt0_v, gnt1_v, sel_v, valid_v;
    logic [7:0] bus_v [2];

    int checks = 0;
    int errors = 0;

    // Model: owner -1 means nobody holds the bus.
    int m_owner [2] = '{-1, -1};
    int m_last  [2] = '{1, 1};
    int m_sel   [2] = '{0, 0};
    int m_wait  [2] = '{0, 0};

    always #5 clk = ~clk;

    bus_arbiter2 #(.WIDTH(8), .MAX_HOLD(4), .CNT_W(3)) u_dut_hold4 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
        .gnt0(gnt0_v[0]), .gnt1(gnt1_v[0]), .sel(sel_v[0]), .bus_valid(valid_v[0]),
        .bus_out(bus_v[0])
    );

    bus_arbiter2 #(.WIDTH(8), .MAX_HOLD(0), .CNT_W(3)) u_dut_hold0 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
        .gnt0(gnt0_v[1]), .gnt1(gnt1_v[1]), .sel(sel_v[1]), .bus_valid(valid_v[1]),
        .bus_out(bus_v[1])
    );

    function automatic void model_take(int k, int idx);
        m_owner[k] = idx;
        m_last[k]  = idx;
        m_sel[k]   = idx;
        m_wait[k]  = 0;
    endfunction

    function automatic void model_step(int k, int max_hold);
        bit want [2];
        int n;
        want[0] = req0;
        want[1] = req1;
        if (m_owner[k] < 0) begin
            if (want[0] && want[1]) model_take(k, 1 - m_last[k]);
            else if (want[0])       model_take(k, 0);
            else if (want[1])       model_take(k, 1);
        end else begin
            n = m_owner[k];
            if (!want[n]) begin
                if (want[1-n]) model_take(k, 1 - n);
                else           m_owner[k] = -1;
            end else if (want[1-n]) begin
                m_wait[k]++;
                if (max_hold != 0 && m_wait[k] >= max_hold) model_take(k, 1 - n);
            end else begin
                m_wait[k] = 0;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_owner[k] = -1;
                m_last[k]  = 1;
                m_sel[k]   = 0;
                m_wait[k]  = 0;
            end
        end else begin
            model_step(0, 4);
            model_step(1, 0);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; din0 = 8'hA5; din1 = 8'h5A;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (gnt0_v[k] !== 1'b0 || gnt1_v[k] !== 1'b0 || sel_v[k] !== 1'b0 ||
                valid_v[k] !== 1'b0 || bus_v[k] !== 8'h00) begin
                errors++;
                $display("FAIL reset_state[%0d]: gnt0=%b gnt1=%b sel=%b valid=%b bus=%h, expected 0 0 0 0 00",
                         k, gnt0_v[k], gnt1_v[k], sel_v[k], valid_v[k], bus_v[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (gnt0_v[k] !== 1'b1 || gnt1_v[k] !== 1'b0 || sel_v[k] !== 1'b0 || bus_v[k] !== 8'hA5) begin
                errors++;
                $display("FAIL first_grant[%0d]: gnt0=%b gnt1=%b sel=%b bus=%h, expected 1 0 0 a5",
                         k, gnt0_v[k], gnt1_v[k], sel_v[k], bus_v[k]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        req1 = 1'b1; din1 = 8'h3C; din0 = 8'hFF;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (gnt1_v[k] !== 1'b1 || gnt0_v[k] !== 1'b0 || sel_v[k] !== 1'b1 || bus_v[k] !== 8'h3C) begin
                    errors++;
                    $display("FAIL single_hold[%0d] cyc %0d: gnt0=%b gnt1=%b sel=%b bus=%h, expected 0 1 1 3c",
                             k, i, gnt0_v[k], gnt1_v[k], sel_v[k], bus_v[k]);
                end
            end
        end
        req1 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (gnt1_v[k] !== 1'b0 || valid_v[k] !== 1'b0 || bus_v[k] !== 8'h00 || sel_v[k] !== 1'b1) begin
                errors++;
                $display("FAIL single_release[%0d]: gnt1=%b valid=%b bus=%h sel=%b, expected 0 0 00 1 (sel holds)",
                         k, gnt1_v[k], valid_v[k], bus_v[k], sel_v[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        req0 = 1'b1; din0 = 8'h11; din1 = 8'h22;
        @(negedge clk);
        checks++;
        if (gnt0_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL rr_setup_g0: gnt0=%b, expected 1", gnt0_v[0]);
        end
        req0 = 1'b0;
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (gnt1_v[k] !== 1'b1 || gnt0_v[k] !== 1'b0 || bus_v[k] !== 8'h22) begin
                errors++;
                $display("FAIL rr_contest[%0d]: gnt0=%b gnt1=%b bus=%h, expected 0 1 22",
                         k, gnt0_v[k], gnt1_v[k], bus_v[k]);
            end
        end
        req1 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (gnt0_v[k] !== 1'b1 || gnt1_v[k] !== 1'b0 || sel_v[k] !== 1'b0 || bus_v[k] !== 8'h11) begin
                errors++;
                $display("FAIL rr_handover[%0d]: gnt0=%b gnt1=%b sel=%b bus=%h, expected 1 0 0 11",
                         k, gnt0_v[k], gnt1_v[k], sel_v[k], bus_v[k]);
            end
        end
        req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_preempt();
        logic exp_g1;
        req0 = 1'b1; din0 = 8'h81; din1 = 8'h42;
        @(negedge clk);
        req1 = 1'b1;
        // G0 for 4 cycles of req1 waiting, G1 for 4, then back to G0.
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            exp_g1 = (i >= 4 && i <= 7);
            checks++;
            if (gnt1_v[0] !== exp_g1 || gnt0_v[0] !== ~exp_g1 || sel_v[0] !== exp_g1 ||
                bus_v[0] !== (exp_g1 ? 8'h42 : 8'h81)) begin
                errors++;
                $display("FAIL preempt cyc %0d: gnt0=%b gnt1=%b sel=%b bus=%h, expected gnt1=%b",
                         i, gnt0_v[0], gnt1_v[0], sel_v[0], bus_v[0], exp_g1);
            end
            checks++;
            if (gnt0_v[1] !== 1'b1 || gnt1_v[1] !== 1'b0) begin
                errors++;
                $display("FAIL preempt_nohold cyc %0d: gnt0=%b gnt1=%b, expected 1 0",
                         i, gnt0_v[1], gnt1_v[1]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_preempt();
        // Last owner on the MAX_HOLD=0 instance was source 0, so source 1 wins.
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (gnt1_v[1] !== 1'b1 || gnt0_v[1] !== 1'b0) begin
                errors++;
                $display("FAIL no_preempt cyc %0d: gnt0=%b gnt1=%b, expected 0 1",
                         i, gnt0_v[1], gnt1_v[1]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        req1 = 1'b1; din1 = 8'h77;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (gnt1_v[k] !== 1'b0 || sel_v[k] !== 1'b0 || valid_v[k] !== 1'b0 || bus_v[k] !== 8'h00) begin
                errors++;
                $display("FAIL async_reset[%0d]: gnt1=%b sel=%b valid=%b bus=%h, expected 0 0 0 00",
                         k, gnt1_v[k], sel_v[k], valid_v[k], bus_v[k]);
            end
        end
        req0 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (gnt0_v[k] !== 1'b1 || gnt1_v[k] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_grant[%0d]: gnt0=%b gnt1=%b, expected 1 0",
                         k, gnt0_v[k], gnt1_v[k]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic       e_g0, e_g1, e_sel;
        logic [7:0] e_bus;
        for (int c = 0; c < 400; c++) begin
            req0 = ($urandom_range(0, 3) != 0) ? req0 : ~req0;
            req1 = ($urandom_range(0, 3) != 0) ? req1 : ~req1;
            din0 = 8'($urandom);
            din1 = 8'($urandom);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                e_g0  = (m_owner[k] == 0);
                e_g1  = (m_owner[k] == 1);
                e_sel = (m_sel[k] != 0);
                e_bus = (m_owner[k] < 0) ? 8'h00 : (e_sel ? din1 : din0);
                checks++;
                if (gnt0_v[k] !== e_g0 || gnt1_v[k] !== e_g1 || sel_v[k] !== e_sel ||
                    valid_v[k] !== (e_g0 | e_g1) || bus_v[k] !== e_bus) begin
                    errors++;
                    $display("FAIL random[%0d] cyc %0d: gnt0=%b gnt1=%b sel=%b valid=%b bus=%h, expected %b %b %b %b %h",
                             k, c, gnt0_v[k], gnt1_v[k], sel_v[k], valid_v[k], bus_v[k],
                             e_g0, e_g1, e_sel, e_g0 | e_g1, e_bus);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_preempt();
        test_no_preempt();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bus_arbiter2
`default_nettype wire

// File: doc/bus_arbiter2.md
Name: bus_arbiter2

Overview:
- Two-requester arbiter that owns the select line of the shared 8-bit data bus feeding the register file / accumulator path.
- Grants the bus to one requester at a time, for example ALU result versus memory read data.
- Round-robin priority, with an optional forced-release limit so neither source starves the other.
- Drives the 2:1 bus mux select and gates the muxed data onto bus_out.

Parameters:
- WIDTH, 8, data bus width in bits.
- MAX_HOLD, 4, maximum consecutive grant cycles while the other requester waits; 0 disables preemption.
- CNT_W, 3, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  bus request from source 0, held high while the bus is wanted.
- req1  input  1  bus request from source 1.
- din0  input  WIDTH  data from source 0.
- din1  input  WIDTH  data from source 1.
- gnt0  output  1  registered grant to source 0.
- gnt1  output  1  registered grant to source 1.
- sel  output  1  registered mux select (0 = din0, 1 = din1).
- bus_valid  output  1  gnt0 | gnt1.
- bus_out  output  WIDTH  the din selected by sel when bus_valid is 1, else all zeros.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-grant):
  - state=IDLE, gnt0=0, gnt1=0, sel=0, last=1, hold_cnt=0.
  - bus_valid=0, bus_out=0.
  - last=1 means req0 wins the first contest.
- States: IDLE, G0, G1; one-hot or binary encoding is free. gnt0 = (state==G0), gnt1 = (state==G1); both registered, never both 1.
- Latency: a request sampled high in IDLE gives a grant on the next rising edge (1 cycle). bus_out/bus_valid are combinational from registered sel/state, so there are no further cycles.
- IDLE transitions:
  - req0 & !req1 -> G0.
  - req1 & !req0 -> G1.
  - both high -> G(1-last).
  - neither -> stay IDLE.
- Gn transitions (n = current owner, m = other):
  - reqn low, reqm high -> Gm directly; one-cycle handover, no IDLE gap.
  - reqn low, reqm low -> IDLE.
  - reqn high, reqm high, MAX_HOLD != 0, hold_cnt == MAX_HOLD-1 -> Gm (preemption).
  - otherwise stay in Gn.
- On every entry to G0 or G1: sel <= index of the new owner, last <= that index, hold_cnt <= 0.
- hold_cnt while in Gn:
  - increments each cycle while reqm is high.
  - held at 0 while reqm is low, so a lone requester keeps the bus indefinitely.
  - never wraps; preemption happens before overflow.
- sel in IDLE holds its last value; bus_out is forced to 0 in IDLE.
- A preempted requester that keeps req high is re-granted by normal round-robin once the other releases or is itself preempted.
- Requests are level-sensitive. A req pulse shorter than one cycle between edges is ignored. Requesters must hold req until they see their grant.

Decomposition:
- Shared package `aardvark_bus_pkg`:
  - state encoding constants ST_IDLE, ST_G0, ST_G1.
  - BUS_W = 8 default.
- Sub-module `bus_mux2_w`: parameterised WIDTH-bit 2:1 mux (sel, in0, in1 -> out). It is instantiated for the data path.
- The zero-gating on bus_valid is done in the arbiter top.

Test Plan:
- Reset: rst_n low with req0=req1=1 -> gnt0=gnt1=0, sel=0, bus_out=8'h00. Release rst_n -> gnt0=1 one edge later, sel=0, bus_out=din0 (drive 8'hA5, expect 8'hA5).
- Single requester: req1=1 only for 10 cycles, din1=8'h3C -> gnt1=1 from cycle 1 through 10. No preemption. bus_out=8'h3C. Drop req1 -> IDLE next edge, bus_out=8'h00.
- Round-robin on simultaneous request: after G0 and return to IDLE, assert req0=req1=1 on the same edge -> G1 granted (last was 0). Release req1 -> G0 the next edge with no idle cycle.
- Preemption with MAX_HOLD=4: G0 active, req1 rises -> gnt0 stays high exactly 4 cycles counted from req1 rising, then gnt1=1, sel=1. With req0 still high, G0 returns 4 cycles later.
- MAX_HOLD=0: both req held high for 20 cycles -> the first owner keeps the grant all 20 cycles.
- Async reset mid-grant: assert rst_n low between clock edges while in G1 -> gnt1, sel and bus_valid drop immediately without waiting for clk. The first grant after release goes to req0.
